// File: rtl/sample_sequencer.sv
// Tick-driven acquisition controller: starts the periodic timer, runs one req/ack
// handshake per tick, flags ack timeouts and counts ticks missed while busy.
module sample_sequencer #(
   parameter int unsigned TIMEOUT = 1000,
   parameter int unsigned MISS_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              tick,
   output logic              t_start,
   output logic              t_restart,
   output logic              req,
   input  logic              ack,
   output logic              done,
   output logic              busy,
   output logic [MISS_W-1:0] overrun_cnt,
   output logic              timeout_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};

   typedef enum logic [1:0] {IDLE, ARM, WAIT_TICK, REQ} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               t_start_d, t_restart_d, req_d, done_d, busy_d, err_d;
   logic [MISS_W-1:0]  overrun_d;

   // State, handshake counter and every output register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         t_start     <= 1'b0;
         t_restart   <= 1'b0;
         req         <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         overrun_cnt <= '0;
         timeout_err <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         t_start     <= t_start_d;
         t_restart   <= t_restart_d;
         req         <= req_d;
         done        <= done_d;
         busy        <= busy_d;
         overrun_cnt <= overrun_d;
         timeout_err <= err_d;
      end
   end

   // Next state and next values of the registered outputs
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      t_start_d   = 1'b0;
      t_restart_d = 1'b0;
      req_d       = 1'b0;
      done_d      = 1'b0;
      busy_d      = 1'b0;
      overrun_d   = overrun_cnt;
      err_d       = timeout_err;

      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d   = ARM;
               t_start_d = 1'b1;
            end
         end
         ARM: begin
            state_d = WAIT_TICK;
         end
         WAIT_TICK: begin
            if (!enable) begin
               state_d     = IDLE;
               t_restart_d = 1'b1;
            end else if (tick) begin
               state_d = REQ;
               req_d   = 1'b1;
               busy_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         REQ: begin
            req_d  = 1'b1;
            busy_d = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            if (ack && tick && enable) begin
               // back-to-back: the coincident tick opens the next handshake
               done_d = 1'b1;
               cnt_d  = '0;
            end else if (ack) begin
               done_d = 1'b1;
               req_d  = 1'b0;
               busy_d = 1'b0;
               if (enable) begin
                  state_d = WAIT_TICK;
               end else begin
                  state_d     = IDLE;
                  t_restart_d = 1'b1;
               end
            end else if (cnt_q == CNT_LAST) begin
               req_d       = 1'b0;
               busy_d      = 1'b0;
               err_d       = 1'b1;
               t_restart_d = 1'b1;
               state_d     = enable ? WAIT_TICK : IDLE;
               if (tick && overrun_cnt != MISS_MAX) overrun_d = overrun_cnt + MISS_W'(1);
            end else if (tick) begin
               if (overrun_cnt != MISS_MAX) overrun_d = overrun_cnt + MISS_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
